vga_timing_gen_p: RTL and testbench

- Parametrised, runtime-reprogrammable video timing generator; successor to the fixed-mode VGA sync generator.
- Produces HS/VS/DE with configurable polarity, plus active-area pixel coordinates and frame/line strobes for the pixel source.
- Sync/DE outputs are delayed by a parametrised pipeline depth so they stay aligned with a downstream image generator of known latency.
- Timing registers are double-buffered and take effect only at a frame boundary.

---
 rtl/vga_timing_gen_p.sv | 181 ++++++++++++++++++
 tb/tb_vga_timing_gen_p.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen_p.sv
// Reprogrammable video timing generator: HS/VS/DE with selectable polarity, active-area
// coordinates and frame/line strobes. Timing changes land only on frame boundaries or while idle.
module vga_timing_gen_p #(
    parameter int unsigned CW          = 12,
    parameter int unsigned PIPE_DLY    = 2,
    parameter bit          HS_POL      = 1'b0,
    parameter bit          VS_POL      = 1'b0,
    parameter int unsigned DEF_H_TOTAL = 799,
    parameter int unsigned DEF_H_SYNC  = 96,
    parameter int unsigned DEF_H_START = 144,
    parameter int unsigned DEF_H_END   = 784,
    parameter int unsigned DEF_V_TOTAL = 524,
    parameter int unsigned DEF_V_SYNC  = 2,
    parameter int unsigned DEF_V_START = 35,
    parameter int unsigned DEF_V_END   = 515
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          enable,
    input  logic [CW-1:0] cfg_h_total,
    input  logic [CW-1:0] cfg_h_sync,
    input  logic [CW-1:0] cfg_h_start,
    input  logic [CW-1:0] cfg_h_end,
    input  logic [CW-1:0] cfg_v_total,
    input  logic [CW-1:0] cfg_v_sync,
    input  logic [CW-1:0] cfg_v_start,
    input  logic [CW-1:0] cfg_v_end,
    input  logic          cfg_update,
    output logic          cfg_ack,
    output logic [CW-1:0] pix_x,
    output logic [CW-1:0] pix_y,
    output logic          pix_valid,
    output logic          sof,
    output logic          eol,
    output logic          vga_hs,
    output logic          vga_vs,
    output logic          vga_de
);

    typedef struct packed {
        logic [CW-1:0] h_total;
        logic [CW-1:0] h_sync;
        logic [CW-1:0] h_start;
        logic [CW-1:0] h_end;
        logic [CW-1:0] v_total;
        logic [CW-1:0] v_sync;
        logic [CW-1:0] v_start;
        logic [CW-1:0] v_end;
    } timing_t;

    localparam timing_t DEF_TIMING = '{
        h_total: CW'(DEF_H_TOTAL), h_sync: CW'(DEF_H_SYNC),
        h_start: CW'(DEF_H_START), h_end:  CW'(DEF_H_END),
        v_total: CW'(DEF_V_TOTAL), v_sync: CW'(DEF_V_SYNC),
        v_start: CW'(DEF_V_START), v_end:  CW'(DEF_V_END)
    };

    // Sync word layout {hs, vs, de}, polarity already applied.
    localparam logic [2:0] SYNC_IDLE = {!HS_POL, !VS_POL, 1'b0};

    timing_t       act_q, act_d, pend_q, pend_d, cfg_in;
    logic          pend_flag_q, pend_flag_d;
    logic [CW-1:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
    logic          h_wrap, frame_end, apply;
    logic          hs_act, vs_act, h_act, v_act, de;
    logic [CW-1:0] pix_x_q, pix_x_d, pix_y_q, pix_y_d;
    logic          pix_valid_q, sof_q, sof_d, eol_q, eol_d, cfg_ack_q;
    logic [2:0]    sync_d;
    logic [2:0]    dly_q [PIPE_DLY+1];

    assign cfg_in = '{
        h_total: cfg_h_total, h_sync: cfg_h_sync, h_start: cfg_h_start, h_end: cfg_h_end,
        v_total: cfg_v_total, v_sync: cfg_v_sync, v_start: cfg_v_start, v_end: cfg_v_end
    };

    assign h_wrap    = (h_cnt_q == act_q.h_total);
    assign frame_end = h_wrap && (v_cnt_q == act_q.v_total);

    // cfg_update is a single-cycle strobe with no back-pressure: every pulse is accepted and
    // overwrites the pending set; cfg_ack pulses once, the cycle after a pending set goes live.
    assign apply = pend_flag_q && (frame_end || !enable);

    always_comb begin
        act_d       = act_q;
        pend_d      = pend_q;
        pend_flag_d = pend_flag_q;
        if (apply) begin
            act_d       = pend_q;
            pend_flag_d = 1'b0;
        end
        if (cfg_update) begin
            pend_d      = cfg_in;
            pend_flag_d = 1'b1;
        end
    end

    always_comb begin
        h_cnt_d = '0;
        v_cnt_d = '0;
        if (enable) begin
            h_cnt_d = h_wrap ? '0 : h_cnt_q + CW'(1);
            v_cnt_d = v_cnt_q;
            if (h_wrap) begin
                v_cnt_d = (v_cnt_q == act_q.v_total) ? '0 : v_cnt_q + CW'(1);
            end
        end
    end

    assign hs_act = (h_cnt_q < act_q.h_sync);
    assign vs_act = (v_cnt_q < act_q.v_sync);
    assign h_act  = (h_cnt_q >= act_q.h_start) && (h_cnt_q < act_q.h_end);
    assign v_act  = (v_cnt_q >= act_q.v_start) && (v_cnt_q < act_q.v_end);
    assign de     = enable && h_act && v_act;

    always_comb begin
        pix_x_d = '0;
        pix_y_d = '0;
        if (de) begin
            pix_x_d = h_cnt_q - act_q.h_start;
            pix_y_d = v_cnt_q - act_q.v_start;
        end
        sof_d  = de && (pix_x_d == '0) && (pix_y_d == '0);
        eol_d  = de && (h_cnt_q == act_q.h_end - CW'(1));
        sync_d = {(enable && hs_act) ? HS_POL : !HS_POL,
                  (enable && vs_act) ? VS_POL : !VS_POL,
                  de};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            act_q       <= DEF_TIMING;
            pend_q      <= DEF_TIMING;
            pend_flag_q <= 1'b0;
            h_cnt_q     <= '0;
            v_cnt_q     <= '0;
            pix_x_q     <= '0;
            pix_y_q     <= '0;
            pix_valid_q <= 1'b0;
            sof_q       <= 1'b0;
            eol_q       <= 1'b0;
            cfg_ack_q   <= 1'b0;
        end else begin
            act_q       <= act_d;
            pend_q      <= pend_d;
            pend_flag_q <= pend_flag_d;
            h_cnt_q     <= h_cnt_d;
            v_cnt_q     <= v_cnt_d;
            pix_x_q     <= pix_x_d;
            pix_y_q     <= pix_y_d;
            pix_valid_q <= de;
            sof_q       <= sof_d;
            eol_q       <= eol_d;
            cfg_ack_q   <= apply;
        end
    end

    // Stage 0 is aligned with the coordinate group; the last stage drives the pins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i <= int'(PIPE_DLY); i++) begin
                dly_q[i] <= SYNC_IDLE;
            end
        end else begin
            dly_q[0] <= sync_d;
            for (int i = 1; i <= int'(PIPE_DLY); i++) begin
                dly_q[i] <= dly_q[i-1];
            end
        end
    end

    assign pix_x     = pix_x_q;
    assign pix_y     = pix_y_q;
    assign pix_valid = pix_valid_q;
    assign sof       = sof_q;
    assign eol       = eol_q;
    assign cfg_ack   = cfg_ack_q;
    assign vga_hs    = dly_q[PIPE_DLY][2];
    assign vga_vs    = dly_q[PIPE_DLY][1];
    assign vga_de    = dly_q[PIPE_DLY][0];

endmodule

// File: tb/tb_vga_timing_gen_p.sv
// Bench for vga_timing_gen_p: random reprogramming and enable activity compared cycle by
// cycle against a frame-position model, plus latency and per-frame aggregate checks.
module tb_vga_timing_gen_p;

    localparam int CW       = 12;
    localparam int PIPE_DLY = 3;
    localparam bit HS_POL   = 1'b0;
    localparam bit VS_POL   = 1'b1;

    typedef struct {
        int ht, hs, hst, hend, vt, vs, vst, vend;
    } tim_t;

    localparam tim_t DEF_T   = '{39, 4, 8, 36, 19, 2, 4, 17};
    localparam tim_t SMALL_T = '{15, 2, 3, 13, 7, 1, 2, 6};

    logic          clk, reset_n, enable, cfg_update;
    logic [CW-1:0] cfg_h_total, cfg_h_sync, cfg_h_start, cfg_h_end;
    logic [CW-1:0] cfg_v_total, cfg_v_sync, cfg_v_start, cfg_v_end;
    logic          cfg_ack, pix_valid, sof, eol, vga_hs, vga_vs, vga_de;
    logic [CW-1:0] pix_x, pix_y;

    int n_checks = 0;
    int n_errors = 0;

    vga_timing_gen_p #(
        .CW(CW), .PIPE_DLY(PIPE_DLY), .HS_POL(HS_POL), .VS_POL(VS_POL),
        .DEF_H_TOTAL(39), .DEF_H_SYNC(4), .DEF_H_START(8), .DEF_H_END(36),
        .DEF_V_TOTAL(19), .DEF_V_SYNC(2), .DEF_V_START(4), .DEF_V_END(17)
    ) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable),
        .cfg_h_total(cfg_h_total), .cfg_h_sync(cfg_h_sync),
        .cfg_h_start(cfg_h_start), .cfg_h_end(cfg_h_end),
        .cfg_v_total(cfg_v_total), .cfg_v_sync(cfg_v_sync),
        .cfg_v_start(cfg_v_start), .cfg_v_end(cfg_v_end),
        .cfg_update(cfg_update), .cfg_ack(cfg_ack),
        .pix_x(pix_x), .pix_y(pix_y), .pix_valid(pix_valid), .sof(sof), .eol(eol),
        .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_de(vga_de)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #3_000_000;
        n_errors++;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- reference model ----------------
    // Counter state is a position t within the frame: h = t mod (ht+1), v = t div (ht+1).
    tim_t          m_act, m_pend_t;
    bit            m_pend_f;
    int            m_t;
    logic [CW-1:0] e_x, e_y;
    bit            e_valid, e_sof, e_eol, e_ack;
    logic [2:0]    e_sync [PIPE_DLY+1];

    task automatic model_reset();
        m_act = DEF_T; m_pend_t = DEF_T; m_pend_f = 1'b0; m_t = 0;
        e_x = '0; e_y = '0; e_valid = 0; e_sof = 0; e_eol = 0; e_ack = 0;
        for (int i = 0; i <= PIPE_DLY; i++) e_sync[i] = {!HS_POL, !VS_POL, 1'b0};
    endtask

    task automatic model_step();
        int h, v;
        bit de, bnd, app;
        h  = m_t % (m_act.ht + 1);
        v  = m_t / (m_act.ht + 1);
        de = enable && h >= m_act.hst && h < m_act.hend && v >= m_act.vst && v < m_act.vend;
        e_valid = de;
        e_x     = de ? CW'(h - m_act.hst) : '0;
        e_y     = de ? CW'(v - m_act.vst) : '0;
        e_sof   = de && h == m_act.hst && v == m_act.vst;
        e_eol   = de && h == m_act.hend - 1;
        for (int i = PIPE_DLY; i > 0; i--) e_sync[i] = e_sync[i-1];
        e_sync[0] = {(enable && h < m_act.hs) ? HS_POL : !HS_POL,
                     (enable && v < m_act.vs) ? VS_POL : !VS_POL, de};
        bnd   = (h == m_act.ht) && (v == m_act.vt);
        app   = m_pend_f && (bnd || !enable);
        e_ack = app;
        m_t   = (!enable || bnd) ? 0 : m_t + 1;
        if (app) begin
            m_act    = m_pend_t;
            m_pend_f = 1'b0;
        end
        if (cfg_update) begin
            m_pend_t = '{int'(cfg_h_total), int'(cfg_h_sync), int'(cfg_h_start), int'(cfg_h_end),
                         int'(cfg_v_total), int'(cfg_v_sync), int'(cfg_v_start), int'(cfg_v_end)};
            m_pend_f = 1'b1;
        end
    endtask

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) model_reset();
        else          model_step();
    end

    // ---------------- scoreboard ----------------
    task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            chk_eq("coord", {pix_x, pix_y, pix_valid, sof, eol}, {e_x, e_y, e_valid, e_sof, e_eol});
            chk_eq("sync", {vga_hs, vga_vs, vga_de}, e_sync[PIPE_DLY]);
            chk_eq("ack", cfg_ack, e_ack);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic apply_cfg(input tim_t t);
        cfg_h_total = CW'(t.ht);  cfg_h_sync  = CW'(t.hs);
        cfg_h_start = CW'(t.hst); cfg_h_end   = CW'(t.hend);
        cfg_v_total = CW'(t.vt);  cfg_v_sync  = CW'(t.vs);
        cfg_v_start = CW'(t.vst); cfg_v_end   = CW'(t.vend);
        cfg_update  = 1'b1;
        @(negedge clk);
        cfg_update  = 1'b0;
    endtask

    function automatic tim_t rand_tim();
        tim_t t;
        t.ht   = $urandom_range(30, 8);
        t.hs   = $urandom_range(3, 1);
        t.hst  = t.hs + $urandom_range(2, 0);
        t.hend = $urandom_range(t.ht + 1, t.hst + 1);
        t.vt   = $urandom_range(10, 3);
        t.vs   = 1;
        t.vst  = t.vs + $urandom_range(1, 0);
        t.vend = $urandom_range(t.vt + 1, t.vst + 1);
        return t;
    endfunction

    function automatic int frame_len(input tim_t t);
        return (t.ht + 1) * (t.vt + 1);
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk_eq({tag, "_coord"}, {pix_x, pix_y, pix_valid, sof, eol}, '0);
        chk_eq({tag, "_sync"}, {vga_hs, vga_vs, vga_de}, {!HS_POL, !VS_POL, 1'b0});
        chk_eq({tag, "_ack"}, cfg_ack, 1'b0);
    endtask

    // Counts clock edges from a restart until sof is seen.
    task automatic measure_sof(input tim_t t, input string tag);
        int n;
        n = -1;
        for (int i = 1; i <= 20000; i++) begin
            @(negedge clk);
            if (sof) begin
                n = i;
                break;
            end
        end
        chk_eq(tag, n, t.vst * (t.ht + 1) + t.hst + 1);
    endtask

    // One full frame period starting at a sof: active pixels, sof count, hs-active cycles.
    task automatic frame_stats(input tim_t t, input string tag);
        int fl, de_n, sof_n, hs_n, eol_n;
        bit seen;
        fl = frame_len(t); de_n = 0; sof_n = 0; hs_n = 0; eol_n = 0; seen = 0;
        for (int i = 0; i < 4 * fl + 50; i++) begin
            if (sof) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        chk_eq({tag, "_sof_seen"}, seen, 1'b1);
        for (int i = 0; i < fl; i++) begin
            de_n  += int'(pix_valid);
            sof_n += int'(sof);
            eol_n += int'(eol && pix_x == CW'(t.hend - t.hst - 1));
            hs_n  += int'(vga_hs == HS_POL);
            @(negedge clk);
        end
        chk_eq({tag, "_de_cnt"}, de_n, (t.hend - t.hst) * (t.vend - t.vst));
        chk_eq({tag, "_sof_cnt"}, sof_n, 1);
        chk_eq({tag, "_eol_cnt"}, eol_n, t.vend - t.vst);
        chk_eq({tag, "_hs_cnt"}, hs_n, (t.vt + 1) * t.hs);
    endtask

    task automatic count_acks(input int n, input int exp, input string tag);
        int acks;
        acks = 0;
        for (int i = 0; i < n; i++) begin
            acks += int'(cfg_ack);
            @(negedge clk);
        end
        chk_eq(tag, acks, exp);
    endtask

    task automatic wait_boundary();
        for (int i = 0; i < 5000; i++) begin
            if (m_t == frame_len(m_act) - 1) return;
            @(negedge clk);
        end
        chk_eq("boundary_wait", 0, 1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        tim_t a, b, c, r;
        reset_n = 1'b1; enable = 1'b0; cfg_update = 1'b0;
        cfg_h_total = '0; cfg_h_sync = '0; cfg_h_start = '0; cfg_h_end = '0;
        cfg_v_total = '0; cfg_v_sync = '0; cfg_v_start = '0; cfg_v_end = '0;
        #1 reset_n = 1'b0;
        #2 check_reset_outputs("rst0");
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        enable  = 1'b1;
        measure_sof(DEF_T, "sof_lat_def");
        frame_stats(DEF_T, "def_f1");
        frame_stats(DEF_T, "def_f2");

        // enable dropped mid-line, restarted 50 clocks later
        for (int i = 0; i < 2000 && !pix_valid; i++) @(negedge clk);
        tick(3);
        enable = 1'b0;
        tick(1 + PIPE_DLY);
        chk_eq("idle_de", {vga_de, pix_valid}, 2'b00);
        tick(50 - 1 - PIPE_DLY);
        enable = 1'b1;
        measure_sof(DEF_T, "sof_lat_restart");

        // mid-frame reprogramming to 10x4
        tick($urandom_range(200, 50));
        apply_cfg(SMALL_T);
        count_acks(frame_len(DEF_T) + 10, 1, "small_ack_cnt");
        frame_stats(SMALL_T, "small");

        // two updates in one frame: only the last one takes effect
        a = rand_tim(); b = rand_tim();
        wait_boundary();
        tick(10);
        apply_cfg(a);
        tick(3);
        apply_cfg(b);
        count_acks(frame_len(SMALL_T) + 5, 1, "ab_ack_cnt");
        frame_stats(b, "ab_b");

        // update on the exact boundary cycle while another set is pending
        a = rand_tim(); c = rand_tim();
        tick(5);
        apply_cfg(a);
        wait_boundary();
        apply_cfg(c);
        count_acks(frame_len(a) + 5, 2, "bnd_ack_cnt");
        frame_stats(c, "bnd_c");

        // random reprogramming with enable drops
        for (int it = 0; it < 20; it++) begin
            r = rand_tim();
            tick($urandom_range(120, 1));
            apply_cfg(r);
            if ($urandom_range(3, 0) == 0) begin
                enable = 1'b0;
                tick($urandom_range(20, 1));
                enable = 1'b1;
            end
            tick($urandom_range(300, 20));
        end

        // asynchronous reset mid-frame with a pending update outstanding
        apply_cfg(rand_tim());
        tick(7);
        #2 reset_n = 1'b0;
        #1 check_reset_outputs("rst_mid");
        @(negedge clk);
        reset_n = 1'b1;
        measure_sof(DEF_T, "sof_lat_after_rst");
        frame_stats(DEF_T, "def_after_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
